// File: rtl/sc_bin_win.sv
// Stochastic-to-binary converter: counts ones over a 2^k valid-bit window and scales to WIDTH bits.
// Optional warm-up skip of WARMUP valid bits is compiled in with macro SC_BIN_WIN_WARMUP_EN.
module sc_bin_win #(
  parameter int WIDTH  = 8,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       win_log2,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

`ifdef SC_BIN_WIN_WARMUP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, ACC = 2'd2, DONE = 2'd3} state_t;
  localparam int WCW     = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam bit WARM_ON = (WARMUP > 0);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd2, DONE = 2'd3} state_t;
`endif

  localparam logic [WIDTH:0] ONE_C = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       k_r;
  logic [3:0]       k_in_s;
  logic [WIDTH:0]   ones_r;
  logic [WIDTH:0]   cnt_r;
  logic [WIDTH:0]   win_len_s;
  logic [WIDTH:0]   ones_nxt_s;
  logic [WIDTH:0]   res_full_s;
  logic [31:0]      shamt_s;
  logic [WIDTH-1:0] res_s;
  logic             last_s;
  logic             hs_s;

`ifdef SC_BIN_WIN_WARMUP_EN
  logic [WCW-1:0]   warm_cnt_r;
  logic             warm_last_s;
`endif

  // Window bookkeeping and the scaled/saturated result for the bit being sampled now.
  always_comb begin
    if ({28'd0, win_log2} > 32'(WIDTH)) begin
      k_in_s = 4'(WIDTH);
    end else begin
      k_in_s = win_log2;
    end
    win_len_s  = ONE_C << k_r;
    last_s     = (cnt_r == (win_len_s - ONE_C));
    ones_nxt_s = ones_r + {{WIDTH{1'b0}}, bit_in};
    shamt_s    = 32'(WIDTH) - {28'd0, k_r};
    res_full_s = ones_nxt_s << shamt_s;
    if (ones_nxt_s == win_len_s) begin
      res_s = {WIDTH{1'b1}};
    end else begin
      res_s = res_full_s[WIDTH-1:0];
    end
    hs_s = res_valid & res_ready;
  end

`ifdef SC_BIN_WIN_WARMUP_EN
  // Warm-up terminal count.
  always_comb begin
    warm_last_s = (warm_cnt_r == WCW'(WARMUP - 1));
  end
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
`ifdef SC_BIN_WIN_WARMUP_EN
          if (WARM_ON) begin
            state_s = WARM;
          end else begin
            state_s = ACC;
          end
`else
          state_s = ACC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef SC_BIN_WIN_WARMUP_EN
      WARM: begin
        if (bit_vld && warm_last_s) begin
          state_s = ACC;
        end else begin
          state_s = WARM;
        end
      end
`endif
      ACC: begin
        if (bit_vld && last_s) begin
          state_s = DONE;
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, window latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r       <= 4'd0;
      ones_r    <= {(WIDTH+1){1'b0}};
      cnt_r     <= {(WIDTH+1){1'b0}};
      result    <= {WIDTH{1'b0}};
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            k_r    <= k_in_s;
            ones_r <= {(WIDTH+1){1'b0}};
            cnt_r  <= {(WIDTH+1){1'b0}};
          end
        end
`ifdef SC_BIN_WIN_WARMUP_EN
        WARM: begin
          if (bit_vld && warm_last_s) begin
            cnt_r <= {(WIDTH+1){1'b0}};
          end
        end
`endif
        ACC: begin
          if (bit_vld) begin
            cnt_r  <= cnt_r + ONE_C;
            ones_r <= ones_nxt_s;
            if (last_s) begin
              result    <= res_s;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (hs_s) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
          res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SC_BIN_WIN_WARMUP_EN
  // Warm-up counter: discarded valid bits since start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt_r <= {WCW{1'b0}};
    end else if (state_r == IDLE) begin
      warm_cnt_r <= {WCW{1'b0}};
    end else if ((state_r == WARM) && bit_vld) begin
      warm_cnt_r <= warm_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
    end else begin
      warm_cnt_r <= warm_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_sc_bin_win.sv
// Directed, table-driven bench for sc_bin_win (WIDTH=8) plus hand sequences for stall, backpressure and reset.
module tb_sc_bin_win;

  localparam int WIDTH = 8;
`ifdef SC_BIN_WIN_WARMUP_EN
  localparam int WARM_N = 16;
`else
  localparam int WARM_N = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       win_log2 = 4'd0;
  logic             bit_in = 1'b0;
  logic             bit_vld = 1'b0;
  logic [WIDTH-1:0] result;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  sc_bin_win #(.WIDTH(WIDTH), .WARMUP(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_log2(win_log2),
    .bit_in(bit_in), .bit_vld(bit_vld), .result(result),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   k;
    int           n;
    logic         alt;
    logic [255:0] pat;
    logic [7:0]   exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start a conversion and feed n valid bits of pat; leaves DUT just entered DONE, sampled at negedge.
  task automatic feed(input logic [3:0] k, input int n, input logic alt, input logic [255:0] pat);
    int idx;
    int cyc;
    @(negedge clk);
    start = 1'b1; win_log2 = k; bit_vld = 1'b0;
    @(negedge clk);
    start = 1'b0; win_log2 = ~k;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int w = 0; w < WARM_N; w++) begin
      bit_in = 1'b0; bit_vld = 1'b1;
      @(negedge clk);
    end
    idx = 0; cyc = 0;
    while (idx < n) begin
      if (alt && cyc[0]) begin
        bit_vld = 1'b0; bit_in = 1'b1;
      end else begin
        if (idx == n - 1) begin
          chk("no_early_valid", {31'd0, res_valid}, 32'd0);
        end
        bit_vld = 1'b1; bit_in = pat[idx];
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    bit_vld = 1'b0; bit_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{k: 4'd4,  n: 16,  alt: 1'b0, pat: 256'h3F,               exp: 8'd96};
    vecs[1] = '{k: 4'd8,  n: 256, alt: 1'b0, pat: {256{1'b1}},           exp: 8'd255};
    vecs[2] = '{k: 4'd8,  n: 256, alt: 1'b0, pat: 256'd0,                exp: 8'd0};
    vecs[3] = '{k: 4'd3,  n: 8,   alt: 1'b1, pat: 256'h4D,               exp: 8'd128};
    vecs[4] = '{k: 4'd0,  n: 1,   alt: 1'b0, pat: 256'h1,                exp: 8'd255};
    vecs[5] = '{k: 4'd0,  n: 1,   alt: 1'b0, pat: 256'h0,                exp: 8'd0};
    vecs[6] = '{k: 4'd12, n: 256, alt: 1'b0, pat: {128'd0, {128{1'b1}}}, exp: 8'd128};
    vecs[7] = '{k: 4'd1,  n: 2,   alt: 1'b0, pat: 256'h3,                exp: 8'd255};
    vecs[8] = '{k: 4'd15, n: 256, alt: 1'b0, pat: {128{2'b10}},          exp: 8'd128};

    repeat (2) @(negedge clk);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      res_ready = 1'b1;
      feed(vecs[v].k, vecs[v].n, vecs[v].alt, vecs[v].pat);
      chk($sformatf("vec%0d_valid", v), {31'd0, res_valid}, 32'd1);
      chk($sformatf("vec%0d_result", v), {24'd0, result}, {24'd0, vecs[v].exp});
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", v), {31'd0, res_valid}, 32'd0);
      chk($sformatf("vec%0d_idle", v), {31'd0, busy}, 32'd0);
    end

    // Backpressure: result held, start ignored in DONE and on the handshake edge.
    res_ready = 1'b0;
    feed(4'd2, 4, 1'b0, 256'h5);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_result", {24'd0, result}, 32'd128);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      start = c[0]; win_log2 = 4'(c);
      @(negedge clk);
    end
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_idle", {31'd0, busy}, 32'd0);
    chk("hs_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("hs_no_restart", {31'd0, busy}, 32'd0);

    // Reset mid-window, then a clean conversion.
    @(negedge clk);
    start = 1'b1; win_log2 = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      bit_vld = 1'b1; bit_in = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    bit_vld = 1'b0; bit_in = 1'b0;
    rst_n = 1'b1;
    feed(4'd2, 4, 1'b0, 256'hB);
    chk("postrst_valid", {31'd0, res_valid}, 32'd1);
    chk("postrst_result", {24'd0, result}, 32'd192);
    @(negedge clk);

`ifdef SC_BIN_WIN_WARMUP_EN
    // Warm-up swallows the leading ones entirely.
    @(negedge clk);
    start = 1'b1; win_log2 = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      chk("warm_busy", {31'd0, busy}, 32'd1);
      chk("warm_no_valid", {31'd0, res_valid}, 32'd0);
      bit_vld = 1'b1; bit_in = (b < 16) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bit_vld = 1'b0;
    chk("warm_valid", {31'd0, res_valid}, 32'd1);
    chk("warm_result", {24'd0, result}, 32'd0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sc_bin_win.md
SC_BIN_WIN -- requirements
Module: sc_bin_win

Interface
REQ-001 SHALL have parameter WIDTH, default 8; result width in bits and maximum log2 window.
REQ-002 SHALL have parameter WARMUP, default 16; number of valid input bits discarded before accumulation when warm-up skip is compiled in.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin one conversion; sampled only in IDLE.
REQ-006 SHALL have port win_log2  input  4  window exponent k; window = 2^k valid bits; sampled with start.
REQ-007 SHALL have port bit_in  input  1  stochastic bitstream, e.g. divider quotient.
REQ-008 SHALL have port bit_vld  input  1  bit_in qualifier; low = stall, bit ignored.
REQ-009 SHALL have port result  output  WIDTH  binary estimate of stream probability, scaled to 2^WIDTH.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WARM, ACC, DONE.
REQ-014 IDLE SHALL go to WARM on start when warm-up is compiled in and WARMUP>0, else to ACC; on the same edge, latch k = min(win_log2, WIDTH) and clear the ones counter and the sample counter.
REQ-015 WARM SHALL count valid bits and discard them; after WARMUP valid bits it SHALL go to ACC and clear the sample counter.
REQ-016 In ACC, each edge with bit_vld=1 SHALL increment the sample counter and add bit_in to the ones counter; edges with bit_vld=0 SHALL change nothing.
REQ-017 When the 2^k-th valid bit is sampled, the FSM SHALL go to DONE and register result on that same edge; res_valid SHALL be high from the following cycle.
REQ-018 result SHALL equal ones << (WIDTH-k), saturated to 2^WIDTH-1 when ones = 2^k (all-ones window).
REQ-019 Counters SHALL be WIDTH+1 bits and SHALL never wrap within a window.
REQ-020 k=0 SHALL give a one-bit window with result either 0 or 2^WIDTH-1.
REQ-021 In DONE, res_valid SHALL stay high and result SHALL stay stable until res_valid and res_ready are both high; on that edge the FSM SHALL return to IDLE.
REQ-022 start SHALL be ignored outside IDLE, including on the edge of a DONE handshake.
REQ-023 win_log2 changes after the start edge SHALL have no effect on the current conversion.
REQ-024 res_valid SHALL be low in IDLE, WARM and ACC.

Reset
REQ-025 Assertion of rst_n SHALL immediately force state IDLE, clear the ones and sample counters, and set result=0, res_valid=0, busy=0; this applies in any state, including mid-window.
REQ-026 After rst_n deasserts, the first edge SHALL behave as IDLE; no partial result SHALL ever be presented.

Configuration
REQ-027 Macro SC_BIN_WIN_WARMUP_EN SHALL control warm-up skip.
REQ-028 With SC_BIN_WIN_WARMUP_EN defined, the WARM state and its counter SHALL exist as described, hiding start-up correlation transients.
REQ-029 Without SC_BIN_WIN_WARMUP_EN, WARM SHALL not exist, WARMUP SHALL be ignored, and IDLE SHALL go directly to ACC.

Verification
REQ-030 SHALL test WIDTH=8, no macro, win_log2=4, bit_vld=1, 16 bits containing 6 ones, res_ready=1 -> result=96, and res_valid pulses 1 cycle on the 18th edge after start.
REQ-031 SHALL test all-ones stream, win_log2=8 -> result=255 (saturated); all-zeros stream -> result=0.
REQ-032 SHALL test win_log2=3 with bit_vld low on alternate cycles, bits 1,0,1,1,0,0,1,0 -> result=128, with stalled cycles not counted.
REQ-033 SHALL test macro defined, WARMUP=16, 16 ones then 16 zeros, win_log2=4 -> result=0, busy high throughout.
REQ-034 SHALL test res_ready held low for 10 cycles in DONE while start pulses -> result stable, res_valid high, no restart; IDLE follows the handshake.
REQ-035 SHALL test rst_n asserted mid-ACC -> all outputs 0 at once; a fresh start then yields a correct result.
